auth_lockout_ctrl: RTL and testbench
====================================

// Module: auth_lockout_ctrl
// PURPOSE
//   Sequential controller downstream of the combinational code comparator.
//   Consumes the comparator's matched/unmatched levels, which are gated by the enter button.
//   Turns each button press into one attempt.
//   Drives a timed unlock, counts consecutive failures and enforces a timed lockout
//   after too many wrong codes.
// PARAMETERS
//   MAX_TRIES    3    consecutive failed attempts that trigger lockout (>=1)
//   OPEN_CYCLES  8    clk cycles unlock stays high after a correct code (>=1)
//   LOCK_CYCLES  16   clk cycles lockout lasts (>=1)
// PORTS
//   clk         in   1   system clock, rising edge
//   rst         in   1   asynchronous, active-high reset
//   matched     in   1   comparator: code equal AND button pressed (level)
//   unmatched   in   1   comparator: code differs AND button pressed (level)
//   unlock      out  1   high while in OPEN
//   locked_out  out  1   high while in LOCKED
//   attempt     out  1   one-cycle pulse per accepted attempt
//   fail_cnt    out  W   consecutive failures, W = $clog2(MAX_TRIES+1)
//   alarm       out  1   present only with AUTH_ALARM_EN (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: async to IDLE. All outputs are 0, the timer is 0, fail_cnt is 0 and the
//     press register is 0. Reset asserted mid-OPEN or mid-LOCKED aborts immediately.
//   - press = matched | unmatched. It is registered every cycle in all states.
//   - Edge: press & ~press_q. A button held across cycles yields exactly one edge.
//   - Attempt accepted only in IDLE on an edge.
//     attempt pulses in the cycle after the edge is sampled, which is the same cycle the
//     state changes.
//   - Edges in OPEN or LOCKED are ignored. No attempt pulse and no counter change.
//     press_q still tracks, so a button held through LOCKED expiry does not count.
//   - matched=1 and unmatched=1 together is illegal input. It is treated as a failure.
//   - FSM:
//       IDLE  --edge & matched & ~unmatched--> OPEN,
//               fail_cnt<=0, timer<=OPEN_CYCLES-1
//       IDLE  --edge & fail, fail_cnt==MAX_TRIES-1--> LOCKED,
//               fail_cnt<=MAX_TRIES, timer<=LOCK_CYCLES-1
//       IDLE  --edge & fail, otherwise--> IDLE, fail_cnt<=fail_cnt+1
//       OPEN  : timer decrements each cycle; timer==0 -> IDLE
//       LOCKED: timer decrements each cycle; timer==0 -> IDLE, fail_cnt<=0
//   - Latency: the edge is sampled at clock edge N. unlock/locked_out are high from
//     edge N+1. They stay high for exactly OPEN_CYCLES/LOCK_CYCLES cycles.
//   - fail_cnt saturates at MAX_TRIES and never wraps.
//     The timer is sized $clog2(max(OPEN_CYCLES,LOCK_CYCLES)) bits (min 1) and never
//     underflows.
//   - Outputs are registered or decoded from the state register only, so they are glitch-free.
// CONFIGURATION
//   AUTH_ALARM_EN defined:
//     - Adds output alarm and an internal 2-bit saturating lockout counter.
//     - The counter increments on each IDLE->LOCKED entry and clears on any OPEN entry.
//     - alarm is high while LOCKED and the counter equals 3. Reset clears the counter.
//   AUTH_ALARM_EN undefined:
//     - The alarm port and the counter do not exist. All other behaviour is identical.
// TESTING
//   1. Assert rst mid-run -> next cycle: unlock=0, locked_out=0, fail_cnt=0, attempt=0.
//   2. IDLE, matched=1 held 5 cycles (OPEN_CYCLES=8)
//      -> one attempt pulse; unlock high exactly 8 cycles; fail_cnt=0.
//   3. Three separate unmatched presses (MAX_TRIES=3)
//      -> fail_cnt 1,2 then 3; locked_out high 16 cycles; then fail_cnt=0.
//   4. Presses (matched or unmatched) during OPEN and LOCKED -> no attempt pulse;
//      state and timer unaffected.
//   5. matched=unmatched=1 edge in IDLE -> counted as a failure, fail_cnt +1.
//   6. AUTH_ALARM_EN: three full lockout cycles with no success -> alarm=1 during the
//      third LOCKED; a correct code afterwards clears it for the next lockout.

Source files
------------

// File: rtl/auth_lockout_ctrl.sv
// Attempt/unlock/lockout sequencer behind the code comparator: one attempt per button press,
// timed unlock, consecutive-failure count and timed lockout. Optional alarm under AUTH_ALARM_EN.
module auth_lockout_ctrl #(
    parameter int MAX_TRIES   = 3,
    parameter int OPEN_CYCLES = 8,
    parameter int LOCK_CYCLES = 16,
    localparam int W = $clog2(MAX_TRIES + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         matched,
    input  logic         unmatched,
    output logic         unlock,
    output logic         locked_out,
    output logic         attempt,
    output logic [W-1:0] fail_cnt
`ifdef AUTH_ALARM_EN
    ,
    output logic         alarm
`endif
);

    localparam int MAXC = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OPEN   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t        state_reg;
    logic [TW-1:0] timer_reg;
    logic          press_reg;
    logic          press;
    logic          press_edge;
    logic          good;

    always_comb begin
        press      = matched | unmatched;
        press_edge = press & ~press_reg;
        // both levels at once is an illegal comparator state and counts as a failure
        good       = matched & ~unmatched;
    end

`ifdef AUTH_ALARM_EN
    logic [1:0] lock_cnt_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            press_reg    <= 1'b0;
            unlock       <= 1'b0;
            locked_out   <= 1'b0;
            attempt      <= 1'b0;
            fail_cnt     <= '0;
`ifdef AUTH_ALARM_EN
            lock_cnt_reg <= 2'd0;
            alarm        <= 1'b0;
`endif
        end else begin
            // press history tracks in every state so a held button never re-triggers
            press_reg <= press;
            attempt   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (press_edge) begin
                        attempt <= 1'b1;
                        if (good) begin
                            state_reg <= OPEN;
                            unlock    <= 1'b1;
                            fail_cnt  <= '0;
                            timer_reg <= TW'(OPEN_CYCLES - 1);
`ifdef AUTH_ALARM_EN
                            lock_cnt_reg <= 2'd0;
`endif
                        end else if (fail_cnt == W'(MAX_TRIES - 1)) begin
                            state_reg  <= LOCKED;
                            locked_out <= 1'b1;
                            fail_cnt   <= W'(MAX_TRIES);
                            timer_reg  <= TW'(LOCK_CYCLES - 1);
`ifdef AUTH_ALARM_EN
                            if (lock_cnt_reg != 2'd3) begin
                                lock_cnt_reg <= lock_cnt_reg + 2'd1;
                            end
                            // the counter's next value is 3 when it is already 2 or saturated
                            alarm <= (lock_cnt_reg >= 2'd2);
`endif
                        end else if (fail_cnt != W'(MAX_TRIES)) begin
                            fail_cnt <= fail_cnt + 1'b1;
                        end
                    end
                end
                OPEN: begin
                    if (timer_reg == '0) begin
                        state_reg <= IDLE;
                        unlock    <= 1'b0;
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                LOCKED: begin
                    if (timer_reg == '0) begin
                        state_reg  <= IDLE;
                        locked_out <= 1'b0;
                        fail_cnt   <= '0;
`ifdef AUTH_ALARM_EN
                        alarm      <= 1'b0;
`endif
                    end else begin
                        timer_reg <= timer_reg - 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    unlock     <= 1'b0;
                    locked_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_auth_lockout_ctrl.sv
// Scoreboard bench for auth_lockout_ctrl: stimulus queues the expected outcome of each
// accepted attempt, a monitor checks attempt pulses and unlock/lockout durations.
module tb_auth_lockout_ctrl;

    localparam int MAX_TRIES   = 3;
    localparam int OPEN_CYCLES = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int W           = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         matched = 1'b0;
    logic         unmatched = 1'b0;
    logic         unlock;
    logic         locked_out;
    logic         attempt;
    logic [W-1:0] fail_cnt;
    logic         alarm;

    typedef struct {
        logic         unlock;
        logic         locked_out;
        logic [W-1:0] fail_cnt;
        logic         alarm;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   lock_model = 0;

    always #5 clk = ~clk;

    auth_lockout_ctrl #(
        .MAX_TRIES  (MAX_TRIES),
        .OPEN_CYCLES(OPEN_CYCLES),
        .LOCK_CYCLES(LOCK_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .matched   (matched),
        .unmatched (unmatched),
        .unlock    (unlock),
        .locked_out(locked_out),
        .attempt   (attempt),
        .fail_cnt  (fail_cnt)
`ifdef AUTH_ALARM_EN
        ,
        .alarm     (alarm)
`endif
    );

`ifndef AUTH_ALARM_EN
    assign alarm = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic exp_ok();
        exp_t e;
        e.unlock = 1'b1; e.locked_out = 1'b0; e.fail_cnt = '0; e.alarm = 1'b0;
        lock_model = 0;
        q.push_back(e);
    endtask

    task automatic exp_fail(input int n);
        exp_t e;
        e.unlock = 1'b0; e.fail_cnt = W'(n); e.locked_out = 1'b0; e.alarm = 1'b0;
        if (n == MAX_TRIES) begin
            e.locked_out = 1'b1;
            if (lock_model < 3) lock_model++;
            e.alarm = (lock_model == 3);
        end
        q.push_back(e);
    endtask

    task automatic press(input logic m, input logic u, input int hold);
        @(posedge clk); #1;
        matched = m; unmatched = u;
        repeat (hold) @(posedge clk);
        #1;
        matched = 1'b0; unmatched = 1'b0;
        $display("press matched=%0b unmatched=%0b hold=%0d", m, u, hold);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic lockout_run();
        exp_fail(1); press(1'b0, 1'b1, 1); idle(1);
        exp_fail(2); press(1'b0, 1'b1, 1); idle(1);
        exp_fail(3); press(1'b0, 1'b1, 1);
        idle(LOCK_CYCLES + 3);
    endtask

    // monitor: checks every attempt pulse against the queue and measures output run lengths
    initial begin
        int   open_run;
        int   lock_run;
        exp_t e;
        open_run = 0;
        lock_run = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                open_run = 0;
                lock_run = 0;
            end else begin
                if (attempt) begin
                    if (q.size() == 0) begin
                        chk("unexpected_attempt", attempt, 0);
                    end else begin
                        e = q.pop_front();
                        chk("attempt_unlock", unlock, e.unlock);
                        chk("attempt_locked", locked_out, e.locked_out);
                        chk("attempt_fail_cnt", fail_cnt, e.fail_cnt);
`ifdef AUTH_ALARM_EN
                        chk("attempt_alarm", alarm, e.alarm);
`endif
                        $display("attempt unlock=%0b locked=%0b fail_cnt=%0d alarm=%0b",
                                 unlock, locked_out, fail_cnt, alarm);
                    end
                end
                if (unlock) open_run++;
                else if (open_run != 0) begin
                    chk("open_len", open_run, OPEN_CYCLES);
                    open_run = 0;
                end
                if (locked_out) lock_run++;
                else if (lock_run != 0) begin
                    chk("lock_len", lock_run, LOCK_CYCLES);
                    chk("fail_cnt_after_lock", fail_cnt, 0);
                    lock_run = 0;
                end
            end
        end
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_unlock", unlock, 0);
        chk("rst_locked", locked_out, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        chk("rst_attempt", attempt, 0);
        #1 rst = 1'b0;

        // correct code held for 5 cycles: a single attempt
        exp_ok(); press(1'b1, 1'b0, 5); idle(12);

        // three failures lock out; presses during LOCKED are ignored
        exp_fail(1); press(1'b0, 1'b1, 1); idle(2);
        exp_fail(2); press(1'b0, 1'b1, 1); idle(2);
        exp_fail(3); press(1'b0, 1'b1, 1); idle(2);
        press(1'b1, 1'b0, 2); press(1'b0, 1'b1, 2);
        idle(LOCK_CYCLES + 2);

        // presses during OPEN are ignored
        exp_ok(); press(1'b1, 1'b0, 1);
        press(1'b0, 1'b1, 1); press(1'b1, 1'b0, 1); press(1'b1, 1'b1, 1);
        idle(OPEN_CYCLES + 2);

        // matched and unmatched together count as a failure; success clears the count
        exp_fail(1); press(1'b1, 1'b1, 1); idle(2);
        exp_ok(); press(1'b1, 1'b0, 1); idle(OPEN_CYCLES + 2);

        // button held through lockout expiry gives no new attempt
        exp_fail(1); press(1'b0, 1'b1, 1); idle(1);
        exp_fail(2); press(1'b0, 1'b1, 1); idle(1);
        exp_fail(3); press(1'b0, 1'b1, LOCK_CYCLES + 4); idle(3);

        // two more lockouts without success: alarm on the third, cleared after a success
        lockout_run();
        lockout_run();
        exp_ok(); press(1'b1, 1'b0, 1); idle(OPEN_CYCLES + 2);
        lockout_run();

        // reset mid-OPEN aborts immediately
        exp_ok(); press(1'b1, 1'b0, 1); idle(3);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midrst_unlock", unlock, 0);
        chk("midrst_locked", locked_out, 0);
        chk("midrst_fail_cnt", fail_cnt, 0);
        chk("midrst_attempt", attempt, 0);
        @(negedge clk); #1 rst = 1'b0;
        lock_model = 0;
        idle(2);
        exp_fail(1); press(1'b0, 1'b1, 1); idle(3);

        chk("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
